klein_64_dec: RTL



---
 rtl/klein_pkg.sv | 103 ++++++++++
 rtl/klein_64_dec_sbox_inv.sv | 12 +
 rtl/klein_64_dec.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/klein_pkg.sv
// KLEIN-64 shared package: round count, 4-bit S-box tables, GF(2^8)
// helpers, InvMix/InvRotate layers, forward/inverse key-step functions
// and the control state enum. Imported by the decryptor and the encryptor.
//
// Vectors are MSB-first: byte 0 of a 64-bit word is [63:56], the left
// 32-bit half is [63:32], the right half is [31:0].
package klein_pkg;

  localparam int unsigned KLEIN_ROUNDS = 12;
  localparam logic [3:0]  RC_FIRST     = 4'd1;
  localparam logic [3:0]  RC_LAST      = 4'(KLEIN_ROUNDS);

  // Nibble n of the table sits at bits [4n+3:4n]. The KLEIN S-box is an
  // involution, so both tables hold the same values.
  localparam logic [63:0] SBOX_TBL     = 64'h5DE8_623C_0BF1_9A47;
  localparam logic [63:0] SBOX_INV_TBL = 64'h5DE8_623C_0BF1_9A47;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_DEC    = 2'd2,
    ST_DONE   = 2'd3
  } klein_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    return SBOX_TBL[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv4(input logic [3:0] n);
    return SBOX_INV_TBL[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse of the AES-style column mix: circulant (0e 0b 0d 09).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] c0, c1, c2, c3;
    c0 = c[31:24];
    c1 = c[23:16];
    c2 = c[15:8];
    c3 = c[7:0];
    return {gmul(c0, 8'h0E) ^ gmul(c1, 8'h0B) ^ gmul(c2, 8'h0D) ^ gmul(c3, 8'h09),
            gmul(c0, 8'h09) ^ gmul(c1, 8'h0E) ^ gmul(c2, 8'h0B) ^ gmul(c3, 8'h0D),
            gmul(c0, 8'h0D) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0E) ^ gmul(c3, 8'h0B),
            gmul(c0, 8'h0B) ^ gmul(c1, 8'h0D) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0E)};
  endfunction

  function automatic logic [63:0] inv_mix(input logic [63:0] s);
    return {inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Undo the 2-byte left nibble rotation of the forward round.
  function automatic logic [63:0] inv_rot(input logic [63:0] s);
    return {s[15:0], s[63:16]};
  endfunction

  // Forward key step: byte-rotate halves, Feistel swap, round constant
  // into byte 2, S-box on bytes 5 and 6.
  function automatic logic [63:0] fk(input logic [63:0] k, input logic [3:0] i);
    logic [31:0] a, b;
    logic [63:0] n;
    a = {k[55:32], k[63:56]};
    b = {k[23:0],  k[31:24]};
    n = {b, a ^ b};
    n[47:40] = n[47:40] ^ {4'd0, i};
    for (int j = 2; j < 6; j++) n[4*j +: 4] = sbox4(n[4*j +: 4]);
    return n;
  endfunction

  // Linear tail of the inverse key step; the caller has already undone
  // the S-box on bytes 5 and 6.
  function automatic logic [63:0] ik_lin(input logic [63:0] k, input logic [3:0] i);
    logic [63:0] t;
    logic [31:0] ar, br;
    t        = k;
    t[47:40] = t[47:40] ^ {4'd0, i};
    ar       = t[31:0] ^ t[63:32];
    br       = t[63:32];
    return {ar[7:0], ar[31:8], br[7:0], br[31:8]};
  endfunction

  function automatic logic [63:0] ik(input logic [63:0] k, input logic [3:0] i);
    logic [63:0] t;
    t = k;
    for (int j = 2; j < 6; j++) t[4*j +: 4] = sbox_inv4(t[4*j +: 4]);
    return ik_lin(t, i);
  endfunction

endpackage

// File: rtl/klein_64_dec_sbox_inv.sv
// klein_sbox_inv: 4-bit KLEIN inverse S-box lookup (purely combinational).
// Ports: din [3:0] nibble in, dout [3:0] substituted nibble out.
module klein_sbox_inv
  import klein_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = sbox_inv4(din);

endmodule

// File: rtl/klein_64_dec.sv
// klein_64_dec: iterative KLEIN-64 decryption core. Expands the master key
// forward to K13 (12 clocks), then runs 12 inverse rounds (one per clock)
// while stepping the key schedule backwards to K1.
//
// Ports:
//   ck    rising-edge clock
//   rst   asynchronous active-high reset
//   start request, sampled only in IDLE/DONE
//   inp   64-bit ciphertext, captured on the accepted start
//   key   64-bit master key, captured on the accepted start
//   busy  high during key expansion and decryption
//   ready high in DONE (out valid)
//   out   64-bit plaintext, held until the next accepted start
//
// Optional feature macro: KLEIN_DEC_KEYCACHE_EN caches K13 of the last
// expanded master key; a repeated key skips the expansion (12-cycle path).
module klein_64_dec
  import klein_pkg::*;
(
  input  logic        ck,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] inp,
  input  logic [63:0] key,
  output logic        busy,
  output logic        ready,
  output logic [63:0] out
);

  klein_state_e state_q, state_d;
  logic [63:0]  sreg_q, sreg_d;
  logic [63:0]  kreg_q, kreg_d;
  logic [63:0]  creg_q, creg_d;
  logic [63:0]  out_q, out_d;
  logic [3:0]   rc_q, rc_d;
  logic         busy_q, busy_d;
  logic         ready_q, ready_d;
`ifdef KLEIN_DEC_KEYCACHE_EN
  logic [63:0]  kcache_q, kcache_d;
  logic [63:0]  kcache_tag_q, kcache_tag_d;
  logic         kcache_vld_q, kcache_vld_d;
`endif

  logic [63:0]  kexp_next;
  logic [63:0]  k_isb;
  logic [63:0]  kdec_next;
  logic [63:0]  d_rot;
  logic [63:0]  d_sub;
  logic [63:0]  dec_next;

  assign kexp_next = fk(kreg_q, rc_q);

  // Inverse key step: only bytes 5 and 6 pass through the S-box.
  assign k_isb[63:24] = kreg_q[63:24];
  assign k_isb[7:0]   = kreg_q[7:0];
  for (genvar g = 0; g < 4; g++) begin : g_key_sb
    klein_sbox_inv u_sb (
      .din  (kreg_q[8+4*g +: 4]),
      .dout (k_isb[8+4*g +: 4])
    );
  end
  assign kdec_next = ik_lin(k_isb, rc_q);

  // Inverse round: InvMix, InvRotate, inverse S-box, add previous round key.
  assign d_rot = inv_rot(inv_mix(sreg_q));
  for (genvar g = 0; g < 16; g++) begin : g_data_sb
    klein_sbox_inv u_sb (
      .din  (d_rot[4*g +: 4]),
      .dout (d_sub[4*g +: 4])
    );
  end
  assign dec_next = d_sub ^ kdec_next;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    kreg_d  = kreg_q;
    creg_d  = creg_q;
    out_d   = out_q;
    rc_d    = rc_q;
`ifdef KLEIN_DEC_KEYCACHE_EN
    kcache_d     = kcache_q;
    kcache_tag_d = kcache_tag_q;
    kcache_vld_d = kcache_vld_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
`ifdef KLEIN_DEC_KEYCACHE_EN
          if (kcache_vld_q && (key == kcache_tag_q)) begin
            sreg_d  = inp ^ kcache_q;
            kreg_d  = kcache_q;
            rc_d    = RC_LAST;
            state_d = ST_DEC;
          end else begin
            creg_d       = inp;
            kreg_d       = key;
            rc_d         = RC_FIRST;
            state_d      = ST_KEYEXP;
            // Tag is taken now; the entry only becomes valid once K13 exists.
            kcache_tag_d = key;
            kcache_vld_d = 1'b0;
          end
`else
          creg_d  = inp;
          kreg_d  = key;
          rc_d    = RC_FIRST;
          state_d = ST_KEYEXP;
`endif
        end
      end
      ST_KEYEXP: begin
        kreg_d = kexp_next;
        if (rc_q == RC_LAST) begin
          // Final whitening key K13 is applied before the first inverse round.
          sreg_d  = creg_q ^ kexp_next;
          rc_d    = RC_LAST;
          state_d = ST_DEC;
`ifdef KLEIN_DEC_KEYCACHE_EN
          kcache_d     = kexp_next;
          kcache_vld_d = 1'b1;
`endif
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      ST_DEC: begin
        sreg_d = dec_next;
        kreg_d = kdec_next;
        if (rc_q == RC_FIRST) begin
          out_d   = dec_next;
          state_d = ST_DONE;
        end else begin
          rc_d = rc_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_KEYEXP) || (state_d == ST_DEC);
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      kreg_q  <= '0;
      creg_q  <= '0;
      out_q   <= '0;
      rc_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef KLEIN_DEC_KEYCACHE_EN
      kcache_q     <= '0;
      kcache_tag_q <= '0;
      kcache_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      kreg_q  <= kreg_d;
      creg_q  <= creg_d;
      out_q   <= out_d;
      rc_q    <= rc_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef KLEIN_DEC_KEYCACHE_EN
      kcache_q     <= kcache_d;
      kcache_tag_q <= kcache_tag_d;
      kcache_vld_q <= kcache_vld_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign out   = out_q;

endmodule
